// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and its sequencer:
// the sign-magnitude Q21.10 format and the sequencer state encoding.
package mac_pkg;
    localparam int DATA_W   = 32;
    localparam int INT_W    = 21;
    localparam int FRAC_W   = 10;
    localparam int SIGN_BIT = 31;

    typedef logic [DATA_W-1:0] fixp_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } mac_seq_state_t;

    localparam fixp_t FIXP_ONE = 32'h0000_0400;
endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for the shared MAC: clears the accumulator,
// streams LEN operand pairs into it, waits out the MAC latency and returns the sum.
module mac_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    abort,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_W-1:0]       op_a,
    input  logic [DATA_W-1:0]       op_b,
    output logic                    mac_rst,
    output logic                    mac_en,
    output logic [DATA_W-1:0]       mac_a,
    output logic [DATA_W-1:0]       mac_b,
    input  logic [DATA_W-1:0]       mac_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic                    busy,
    output mac_pkg::mac_seq_state_t dbg_state
);
    import mac_pkg::*;

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never waits on ready, and the payload is
    // sampled on that same edge.

    localparam int DCNT_W = $clog2(MAC_LAT + 1) + 1;

    mac_seq_state_t    state;
    mac_seq_state_t    state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [DCNT_W-1:0] drain_cnt;
    logic              cfg_fire;
    logic              op_fire;
    logic              res_fire;
    logic              last_beat;
    logic              drain_done;

    assign cfg_ready = (state == IDLE);
    // abort must never look like a consumed pair to the operand source
    assign op_ready  = (state == FEED) && !abort;
    assign mac_rst   = (state == CLEAR);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign op_fire    = op_valid && op_ready;
    assign res_fire   = res_valid && res_ready;
    assign last_beat  = (beat_cnt == (len_q - LEN_W'(1)));
    assign drain_done = (drain_cnt == DCNT_W'(MAC_LAT));

    always_comb begin
        state_nxt = state;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cfg_fire) state_nxt = CLEAR;
                CLEAR:   state_nxt = (len_q != '0) ? FEED : DONE;
                FEED:    if (op_fire && last_beat) state_nxt = DRAIN;
                DRAIN:   if (drain_done) state_nxt = DONE;
                DONE:    if (res_fire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_data  <= '0;
        end else begin
            state  <= state_nxt;
            mac_en <= op_fire;
            if (op_fire) begin
                mac_a <= op_a;
                mac_b <= op_b;
            end

            if (cfg_fire) begin
                len_q    <= cfg_len;
                beat_cnt <= '0;
            end else if (op_fire) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end

            // DRAIN holds MAC_LAT+1 cycles so the final mac_en has settled in mac_out
            if (state == DRAIN) drain_cnt <= drain_cnt + DCNT_W'(1);
            else                drain_cnt <= '0;

            if (!abort) begin
                if (state == CLEAR && len_q == '0) res_data <= '0;
                if (state == DRAIN && drain_done)  res_data <= mac_out;
            end
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural sign-magnitude MAC
// and a dot-product model that predicts results, latencies and MAC traffic.
module tb_mac_seq_ctrl;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    cfg_valid, cfg_ready, abort;
    logic [LEN_W-1:0]        cfg_len;
    logic                    op_valid, op_ready;
    logic [DATA_W-1:0]       op_a, op_b;
    logic                    mac_rst, mac_en;
    logic [DATA_W-1:0]       mac_a, mac_b, mac_out;
    logic                    res_valid, res_ready;
    logic [DATA_W-1:0]       res_data;
    logic                    busy;
    mac_pkg::mac_seq_state_t dbg_state;

    mac_seq_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
        .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- model state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [63:0]       pair_q[$];
    logic              tb_busy = 1'b0;
    logic              mon_on  = 1'b0;
    int                job_en_cnt  = 0;
    int                job_rst_cnt = 0;
    logic [DATA_W-1:0] a_arr[256];
    logic [DATA_W-1:0] b_arr[256];
    int                gap_arr[256];
    longint            mac_acc = 0;

    function automatic longint prod(input logic [31:0] a, input logic [31:0] b);
        longint m;
        m = (longint'(a[30:0]) * longint'(b[30:0])) >>> 10;
        return (a[31] ^ b[31]) ? -m : m;
    endfunction

    function automatic logic [31:0] to_sm(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {(v < 0), m[30:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [13:0] mag;
        logic        sgn;
        mag = 14'($urandom_range(0, 16383));
        sgn = 1'($urandom_range(0, 1));
        return {sgn, 17'b0, mag};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural MAC: registered accumulator, output valid one edge after en.
    always @(posedge clk) begin
        if (mac_rst)     mac_acc <= 0;
        else if (mac_en) mac_acc <= mac_acc + prod(mac_a, mac_b);
    end
    assign mac_out = to_sm(mac_acc);

    // Job-level model of the controller's occupancy and accepted pairs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            tb_busy <= 1'b0;
            pair_q.delete();
        end else begin
            if (tb_busy && abort) tb_busy <= 1'b0;
            else if (!tb_busy && cfg_valid) tb_busy <= 1'b1;
            else if (tb_busy && res_valid && res_ready) begin
                tb_busy <= 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (op_valid && op_ready) pair_q.push_back({op_a, op_b});
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            logic [63:0] p;
            check("busy", busy, tb_busy);
            check("cfg_ready", cfg_ready, !tb_busy);
            if (!tb_busy) begin
                check("idle_res_valid", res_valid, 0);
                check("idle_op_ready", op_ready, 0);
                check("idle_mac_rst", mac_rst, 0);
            end
            if (res_valid) begin
                check("res_valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("res_data", res_data, exp_q[0]);
            end
            if (mac_rst) job_rst_cnt++;
            if (mac_en) begin
                job_en_cnt++;
                check("mac_rst_before_en", job_rst_cnt, 1);
                check("mac_en_expected", pair_q.size() != 0, 1);
                if (pair_q.size() != 0) begin
                    p = pair_q.pop_front();
                    check("mac_a", mac_a, p[63:32]);
                    check("mac_b", mac_b, p[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cfg(input int len, input logic ab, output int t0);
        @(negedge clk);
        job_en_cnt  = 0;
        job_rst_cnt = 0;
        cfg_valid   = 1'b1;
        cfg_len     = LEN_W'(len);
        abort       = ab;
        t0          = cyc;
        check("cfg_ready_at_cfg", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap_arr[i]) begin
                @(posedge clk);
                #1;
            end
            op_valid = 1'b1;
            op_a     = a_arr[i];
            op_b     = b_arr[i];
            begin
                int k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!op_ready && k < 10);
                if (!op_ready) check("op_ready_timeout", op_ready, 1);
            end
            @(posedge clk);
            #1;
            op_valid = 1'b0;
        end
    endtask

    task automatic wait_rv(output int t1);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 600);
        check("res_valid_timeout", res_valid, 1);
        t1 = cyc;
    endtask

    task automatic run_job(input int len, input int hold, input logic ab,
                           output logic [31:0] got, output int lat);
        longint sum  = 0;
        int     gsum = 0;
        int     t0, t1, exp_lat;
        for (int i = 0; i < len; i++) begin
            sum += prod(a_arr[i], b_arr[i]);
            if (i > 0) gsum += gap_arr[i];
        end
        exp_q.push_back(to_sm(sum));
        send_cfg(len, ab, t0);
        feed(len);
        wait_rv(t1);
        lat     = t1 - t0;
        exp_lat = (len == 0) ? 2 : len + gsum + MAC_LAT + 3;
        check("latency", lat, exp_lat);
        got = res_data;
        repeat (hold) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, got);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("mac_en_count", job_en_cnt, len);
        check("mac_rst_count", job_rst_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] got;
        int          lat, t0;
        cfg_valid = 0; cfg_len = '0; abort = 0;
        op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
        for (int i = 0; i < 256; i++) gap_arr[i] = 0;

        // reset: 2 cycles low
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_mac_rst", mac_rst, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(negedge clk);
        check("cfg_ready_after_rst", cfg_ready, 1);

        // positive job: 1*2 + 3*2 + 5*5 = 33.0
        a_arr[0] = 32'h0000_0400; b_arr[0] = 32'h0000_0800;
        a_arr[1] = 32'h0000_0C00; b_arr[1] = 32'h0000_0800;
        a_arr[2] = 32'h0000_1400; b_arr[2] = 32'h0000_1400;
        run_job(3, 0, 1'b0, got, lat);
        check("pos_result", got, 32'h0000_8400);
        check("pos_latency", lat, 7);

        // mixed signs with 2-cycle stalls: 40 + 6 - 12 + 4 = 38.0
        a_arr[0] = 32'h0000_1400; b_arr[0] = 32'h0000_2000;
        a_arr[1] = 32'h0000_0800; b_arr[1] = 32'h0000_0C00;
        a_arr[2] = 32'h8000_0C00; b_arr[2] = 32'h0000_1000;
        a_arr[3] = 32'h8000_0800; b_arr[3] = 32'h8000_0800;
        for (int i = 1; i < 4; i++) gap_arr[i] = 2;
        run_job(4, 1, 1'b0, got, lat);
        check("mixed_result", got, 32'h0000_9800);
        check("mixed_latency", lat, 4 + 6 + 4);
        for (int i = 0; i < 256; i++) gap_arr[i] = 0;

        // zero-length job with back-pressure
        run_job(0, 5, 1'b0, got, lat);
        check("zero_result", got, 32'h0000_0000);
        check("zero_latency", lat, 2);

        // abort after second beat, then a job accepted together with abort
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = rand_op();
            b_arr[i] = rand_op();
        end
        send_cfg(4, 1'b0, t0);
        feed(2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_mac_en", mac_en, 0);
        repeat (5) @(posedge clk);
        a_arr[0] = 32'h0000_0200; b_arr[0] = 32'h0000_0200;
        run_job(1, 0, 1'b1, got, lat);
        check("after_abort_result", got, 32'h0000_0100);

        // reset during DRAIN: job lost, next job starts clean
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 32'h0000_0400 << i;
            b_arr[i] = 32'h0000_0400;
        end
        send_cfg(4, 1'b0, t0);
        feed(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_res_after_rst", res_valid, 0);
        end
        a_arr[0] = 32'h0000_0400; b_arr[0] = 32'h0000_0400;
        run_job(1, 0, 1'b0, got, lat);
        check("after_rst_result", got, 32'h0000_0400);

        // maximum length job, gap-free
        for (int i = 0; i < 255; i++) begin
            a_arr[i] = rand_op();
            b_arr[i] = rand_op();
        end
        run_job(255, 1, 1'b0, got, lat);
        check("max_len_latency", lat, 255 + MAC_LAT + 3);

        // randomized jobs
        for (int j = 0; j < 15; j++) begin
            int len;
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                a_arr[i]   = rand_op();
                b_arr[i]   = rand_op();
                gap_arr[i] = $urandom_range(0, 2);
            end
            run_job(len, $urandom_range(0, 3), 1'b0, got, lat);
        end

        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that computes one dot product per job on the shared MAC datapath.
- MAC datapath: 32-bit sign-magnitude Q21.10 operands (bit31 sign, 21 integer, 10 fraction), registered accumulator, active-high `rst`, `en` qualifies accumulate.
- Per job: accepts a length command, clears the accumulator, streams operand pairs through valid/ready into the MAC, waits out MAC latency, returns the accumulator value on a result handshake.
- Sits between the operand-fetch logic and the MAC in the TPU processing element.

Parameters:
- DATA_W, 32, operand/result width (sign-magnitude Q21.10)
- LEN_W, 8, width of the job length field (max LEN = 2^LEN_W-1)
- MAC_LAT, 1, cycles from MAC `en` sample edge to updated MAC `out`

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cfg_valid  in  1  job command valid
- cfg_ready  out  1  controller can accept a job (IDLE only)
- cfg_len  in  LEN_W  number of operand pairs in the job
- abort  in  1  synchronous job cancel
- op_valid  in  1  operand pair valid
- op_ready  out  1  controller accepts operand pair
- op_a, op_b  in  DATA_W  operand pair
- mac_rst  out  1  to MAC `rst` (active-high accumulator clear)
- mac_en  out  1  to MAC `en`
- mac_a, mac_b  out  DATA_W  to MAC `A`/`B`, registered
- mac_out  in  DATA_W  from MAC `out`
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  dot-product result
- busy  out  1  state != IDLE

Behaviour:
- Reset (`rst_n`=0 at edge): state IDLE, counters 0.
- Reset values: mac_en=0, mac_a=mac_b=0, res_valid=0, res_data=0, op_ready=0, mac_rst=0, busy=0. cfg_ready=1 from the first cycle after reset.
- Reset mid-job: job lost; the MAC is cleared by the next job's CLEAR.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch cfg_len and go to CLEAR.
- CLEAR: one cycle. mac_rst=1 (decoded from state). Next state is FEED if len!=0; else DONE with res_data=0.
- FEED: op_ready=1. On each op_valid&op_ready: mac_a/mac_b<=op_a/op_b, mac_en<=1 (registered, one cycle), beat count +1. With no handshake, mac_en<=0.
- FEED exit: the handshake that brings the count to len moves to DRAIN. Throughput is one pair per cycle; stalls on op_valid are allowed anywhere.
- DRAIN: op_ready=0. Stays MAC_LAT+1 cycles. On the last DRAIN edge, res_data<=mac_out and go to DONE.
- DONE: res_valid=1, res_data stable until res_ready. On res_valid&res_ready, go to IDLE; res_data keeps its value.
- Latency: with gap-free operands, res_valid rises LEN+MAC_LAT+3 cycles after the cfg handshake edge.
- abort: highest priority. From any non-IDLE state, next state is IDLE, mac_en<=0, res_valid<=0; no result is produced.
- abort in IDLE: no effect. abort together with cfg_valid in IDLE: the job is accepted.
- cfg_valid outside IDLE: ignored (cfg_ready=0). op_valid outside FEED: not consumed.
- Arithmetic: the controller never alters operand/result bits; sign-magnitude is passed through. Overflow behaviour belongs to the MAC.
- Beat counter width is LEN_W; cfg_len=2^LEN_W-1 must complete without wrap.

Decomposition:
- Shared package mac_pkg:
  - DATA_W=32, INT_W=21, FRAC_W=10
  - SIGN_BIT=31
  - typedef fixp_t (logic [31:0])
  - typedef enum mac_seq_state_t {IDLE, CLEAR, FEED, DRAIN, DONE}
  - constant FIXP_ONE=32'h0000_0400
- No sub-module: beat and drain counters are inline. Top-level pairing with the MAC lives in a separate wrapper, mac_seq_unit.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs at reset values; cfg_ready=1 after release.
- Positive job: cfg_len=3; pairs (1.0,2.0), (3.0,2.0), (5.0,5.0) gap-free -> res_data=0x0000_8400 (33.0); res_valid exactly 7 cycles after cfg handshake (MAC_LAT=1); mac_rst high one cycle before the first mac_en.
- Mixed-sign job with stalls: cfg_len=4; pairs (5,8), (2,3), (-3=0x8000_0C00,4), (-2,-2); op_valid low 2 cycles between beats -> res_data=38.0 (0x0000_9800); mac_en high exactly 4 cycles.
- Zero-length job: cfg_len=0 -> no mac_en; res_data=0; res_valid 2 cycles after cfg. Back-pressure: hold res_ready=0 for 5 cycles -> res_valid/res_data stable, cfg_ready=0 throughout.
- Abort: cfg_len=4; abort after the 2nd beat -> IDLE next cycle, no res_valid. Following job cfg_len=1, (0.5,0.5) -> res_data=0x0000_0100 (0.25), showing CLEAR wiped the partial sum.
- Reset mid-job: rst_n=0 during DRAIN -> res_valid never rises; next job len=1 (1.0,1.0) -> res_data=0x0000_0400.
